tbb: RTL and testbench

- Task batch buffer: the input-side counterpart of the result batch buffer in the same PE-array datapath.
- Host/AFU side writes a task batch as 512-bit lines. The block then unpacks each line into 16 32-bit words and streams them, in order, to one PE array over a valid/ready handshake.
- After the last word is accepted, the block returns to accepting the next batch.
- One instance per PE array; storage is an nlb_gram_sdp block RAM.

---
 rtl/tbb_pkg.sv | 18 +
 rtl/nlb_gram_sdp.sv | 36 +++
 rtl/tbb_unpack.sv | 96 +++++++++
 rtl/tbb.sv | 138 +++++++++++++
 tb/tb_tbb.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tbb_pkg.sv
// Shared types and constants for the task batch buffer (tbb).
package tbb_pkg;

    localparam int unsigned WORDS_PER_LINE = 16;
    localparam int unsigned WORD_SEL_WIDTH = 4;

    typedef enum logic [1:0] {
        FILL,
        READY,
        DRAIN
    } tbb_state_e;

    // Line count needs one extra bit so a full RAM (all indices used) is representable.
    function automatic int unsigned line_cnt_width(input int unsigned wr_addr_width);
        return wr_addr_width + 1;
    endfunction

endpackage

// File: rtl/nlb_gram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read port.
// GRAM_MODE 1 gives one cycle of read latency; any other mode adds an output register.
module nlb_gram_sdp #(
    parameter int unsigned BUS_SIZE_ADDR = 4,
    parameter int unsigned BUS_SIZE_DATA = 32,
    parameter int unsigned GRAM_MODE     = 1
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [BUS_SIZE_ADDR-1:0] waddr,
    input  logic [BUS_SIZE_DATA-1:0] din,
    input  logic [BUS_SIZE_ADDR-1:0] raddr,
    output logic [BUS_SIZE_DATA-1:0] dout
);

    logic [BUS_SIZE_DATA-1:0] mem [2**BUS_SIZE_ADDR];
    logic [BUS_SIZE_DATA-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= din;
        end
        rd_q <= mem[raddr];
    end

    if (GRAM_MODE == 1) begin : g_lat1
        assign dout = rd_q;
    end else begin : g_lat2
        logic [BUS_SIZE_DATA-1:0] out_q;
        always_ff @(posedge clk) begin
            out_q <= rd_q;
        end
        assign dout = out_q;
    end

endmodule

// File: rtl/tbb_unpack.sv
// Line register, one-line prefetch register and word mux for the tbb drain path.
// Issues its own RAM line reads; the mux output holds while the consumer stalls.
module tbb_unpack
    import tbb_pkg::*;
#(
    parameter int unsigned AddrW = 8,
    parameter int unsigned LineW = 512,
    parameter int unsigned WordW = 32,
    parameter int unsigned IdxW  = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [AddrW:0]   num_lines,
    output logic [AddrW-1:0] rd_addr,
    input  logic [LineW-1:0] rd_data,
    input  logic             dout_ready,
    output logic             dout_valid,
    output logic [WordW-1:0] dout,
    output logic [IdxW-1:0]  dout_idx,
    output logic             dout_last
);

    logic [LineW-1:0] line_q;
    logic [LineW-1:0] pf_q;
    logic [IdxW-1:0]  idx_q;
    logic [AddrW:0]   next_line_q;
    logic             valid_q;
    logic             rd_pend_q;
    logic             load_q;
    logic             rd_en;
    logic             xfer;
    logic             line_end;
    logic [IdxW:0]    last_idx;
    logic [WordW-1:0] words [WORDS_PER_LINE];

    for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_words
        assign words[g] = line_q[g*WordW +: WordW];
    end

    always_comb begin
        xfer       = valid_q & dout_ready;
        line_end   = &idx_q[WORD_SEL_WIDTH-1:0];
        // Next line is fetched once the current one lands in the line register.
        rd_en      = start | (load_q & (next_line_q < num_lines));
        rd_addr    = start ? '0 : next_line_q[AddrW-1:0];
        last_idx   = {num_lines, {WORD_SEL_WIDTH{1'b0}}} - 1'b1;
        dout_valid = valid_q;
        dout_idx   = idx_q;
        dout       = words[idx_q[WORD_SEL_WIDTH-1:0]];
        dout_last  = valid_q & ({1'b0, idx_q} == last_idx);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_q      <= '0;
            pf_q        <= '0;
            idx_q       <= '0;
            next_line_q <= '0;
            valid_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            rd_pend_q <= rd_en;
            load_q    <= 1'b0;
            if (rd_en) begin
                next_line_q <= start ? (AddrW+1)'(1) : next_line_q + 1'b1;
            end
            if (start) begin
                idx_q   <= '0;
                valid_q <= 1'b0;
            end else if (rd_pend_q && !valid_q) begin
                // First line of a batch goes straight to the line register.
                line_q  <= rd_data;
                valid_q <= 1'b1;
                load_q  <= 1'b1;
            end else begin
                if (rd_pend_q) begin
                    pf_q <= rd_data;
                end
                if (xfer) begin
                    if (dout_last) begin
                        valid_q <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        if (line_end) begin
                            line_q <= pf_q;
                            load_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tbb.sv
// Task batch buffer: host loads 512-bit lines, block streams 32-bit words to one PE array.
// Define TBB_STALL_CNT_EN to add the StallCnt output (consumer stall cycles per batch).
module tbb
    import tbb_pkg::*;
#(
    parameter int unsigned TBB_WR_ADDR_WIDTH = 8,
    parameter int unsigned TBB_WR_DATA_WIDTH = 512,
    parameter int unsigned TBB_RD_ADDR_WIDTH = 12,
    parameter int unsigned TBB_RD_DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         WrEn,
    input  logic [TBB_WR_ADDR_WIDTH-1:0] WrLineIdx,
    input  logic [TBB_WR_DATA_WIDTH-1:0] WrDin,
    input  logic                         WrLast,
    output logic                         Full,
    output logic                         Empty,
    output logic                         BatchValid,
    input  logic                         TaskStart,
    output logic                         DoutValid,
    input  logic                         DoutReady,
    output logic [TBB_RD_DATA_WIDTH-1:0] Dout,
    output logic [TBB_RD_ADDR_WIDTH-1:0] DoutIdx,
    output logic                         DoutLast,
    output logic                         TaskDone
`ifdef TBB_STALL_CNT_EN
    ,
    output logic [31:0]                  StallCnt
`endif
);

    localparam int unsigned LineCntW = line_cnt_width(TBB_WR_ADDR_WIDTH);

    tbb_state_e                   state_q, state_d;
    logic [LineCntW-1:0]          num_lines_q, num_lines_d;
    logic                         done_q;
    logic                         start;
    logic                         last_xfer;
    logic                         ram_we;
    logic [TBB_WR_ADDR_WIDTH-1:0] rd_addr;
    logic [TBB_WR_DATA_WIDTH-1:0] rd_data;

    always_comb begin
        state_d     = state_q;
        num_lines_d = num_lines_q;
        ram_we      = 1'b0;
        start       = 1'b0;
        last_xfer   = DoutValid & DoutReady & DoutLast;
        unique case (state_q)
            FILL: begin
                ram_we = WrEn;
                if (WrEn && WrLast) begin
                    num_lines_d = LineCntW'(WrLineIdx) + 1'b1;
                    state_d     = READY;
                end
            end
            READY: begin
                if (TaskStart) begin
                    start   = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_xfer) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            num_lines_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_lines_q <= num_lines_d;
            done_q      <= last_xfer;
        end
    end

    assign Full       = (state_q != FILL);
    assign Empty      = ~Full;
    assign BatchValid = (state_q == READY);
    assign TaskDone   = done_q;

    nlb_gram_sdp #(
        .BUS_SIZE_ADDR (TBB_WR_ADDR_WIDTH),
        .BUS_SIZE_DATA (TBB_WR_DATA_WIDTH),
        .GRAM_MODE     (1)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (WrLineIdx),
        .din   (WrDin),
        .raddr (rd_addr),
        .dout  (rd_data)
    );

    tbb_unpack #(
        .AddrW (TBB_WR_ADDR_WIDTH),
        .LineW (TBB_WR_DATA_WIDTH),
        .WordW (TBB_RD_DATA_WIDTH),
        .IdxW  (TBB_RD_ADDR_WIDTH)
    ) u_unpack (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .num_lines  (num_lines_q),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .dout_ready (DoutReady),
        .dout_valid (DoutValid),
        .dout       (Dout),
        .dout_idx   (DoutIdx),
        .dout_last  (DoutLast)
    );

`ifdef TBB_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if (start) begin
            stall_cnt_q <= '0;
        end else if (state_q == DRAIN && DoutValid && !DoutReady && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tbb.sv
// Directed self-checking bench for tbb: load/drain batches, stalls, ignored inputs, reset.
`timescale 1ns/1ps
module tb_tbb;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         WrEn = 1'b0;
    logic [7:0]   WrLineIdx = '0;
    logic [511:0] WrDin = '0;
    logic         WrLast = 1'b0;
    logic         TaskStart = 1'b0;
    logic         DoutReady = 1'b0;
    logic         Full, Empty, BatchValid, DoutValid, DoutLast, TaskDone;
    logic [31:0]  Dout;
    logic [11:0]  DoutIdx;
`ifdef TBB_STALL_CNT_EN
    logic [31:0]  StallCnt;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  salt = 8'h00;

    always #5 clk = ~clk;

    tbb u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .WrEn       (WrEn),
        .WrLineIdx  (WrLineIdx),
        .WrDin      (WrDin),
        .WrLast     (WrLast),
        .Full       (Full),
        .Empty      (Empty),
        .BatchValid (BatchValid),
        .TaskStart  (TaskStart),
        .DoutValid  (DoutValid),
        .DoutReady  (DoutReady),
        .Dout       (Dout),
        .DoutIdx    (DoutIdx),
        .DoutLast   (DoutLast),
        .TaskDone   (TaskDone)
`ifdef TBB_STALL_CNT_EN
        ,
        .StallCnt   (StallCnt)
`endif
    );

    // Word w of line L = {L[7:0], salt, w[15:0]}; salt is 0 for the standard pattern.
    function automatic logic [31:0] exp_word(input int idx);
        int         l;
        int         w;
        logic [7:0] l8;
        logic [15:0] w16;
        l   = idx / 16;
        w   = idx % 16;
        l8  = l[7:0];
        w16 = w[15:0];
        return {l8, salt, w16};
    endfunction

    function automatic logic [511:0] make_line(input int l);
        logic [511:0] d;
        d = '0;
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = exp_word(l * 16 + w);
        return d;
    endfunction

    task automatic write_line(input int idx, input logic [511:0] data, input logic last);
        WrEn      = 1'b1;
        WrLineIdx = idx[7:0];
        WrDin     = data;
        WrLast    = last;
        @(posedge clk); #1;
        WrEn   = 1'b0;
        WrLast = 1'b0;
    endtask

    task automatic load_batch(input int nlines);
        for (int l = 0; l < nlines; l++) write_line(l, make_line(l), l == nlines - 1);
    endtask

    // Starts a batch and consumes stop_at words; stalls stall_len cycles when idx stall_at shows.
    task automatic drain_batch(input string name, input int nwords, input int stall_at,
                               input int stall_len, input int stop_at);
        int          cnt = 0;
        int          bad = 0;
        int          gaps = 0;
        int          stalls = 0;
        int          cyc = 0;
        int          first_cyc = -1;
        int          bad_idx = -1;
        logic [31:0] bad_dout = '0;
        logic [11:0] bad_didx = '0;
        n_checks++;
        if ({BatchValid, Full} !== 2'b11) begin
            n_fail++;
            $display("FAIL %s ready_state: {BatchValid,Full}=%b required 11", name,
                     {BatchValid, Full});
        end
        TaskStart = 1'b1;
        DoutReady = 1'b1;
        while (cnt < stop_at && cyc < 2 * nwords + 64) begin
            @(posedge clk); #1;
            cyc++;
            TaskStart = 1'b0;
            DoutReady = 1'b1;
            if (DoutValid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (Dout !== exp_word(cnt) || DoutIdx !== cnt[11:0] ||
                    DoutLast !== (cnt == nwords - 1)) begin
                    if (bad == 0) begin
                        bad_idx  = cnt;
                        bad_dout = Dout;
                        bad_didx = DoutIdx;
                    end
                    bad++;
                end
                if (cnt == stall_at && stalls < stall_len) begin
                    DoutReady = 1'b0;
                    stalls++;
                end else begin
                    cnt++;
                end
            end else if (first_cyc >= 0) begin
                gaps++;
            end
        end
        n_checks++;
        if (first_cyc !== 2) begin
            n_fail++;
            $display("FAIL %s first_valid_latency: got %0d cycles, required 2", name, first_cyc);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL %s word_stream: %0d bad; first at word %0d Dout=%h DoutIdx=%0d, required Dout=%h DoutIdx=%0d",
                     name, bad, bad_idx, bad_dout, bad_didx, exp_word(bad_idx), bad_idx);
        end
        n_checks++;
        if (gaps !== 0) begin
            n_fail++;
            $display("FAIL %s no_bubble: %0d idle cycles, required 0", name, gaps);
        end
        n_checks++;
        if (cnt !== stop_at) begin
            n_fail++;
            $display("FAIL %s words_delivered: got %0d, required %0d", name, cnt, stop_at);
        end
        if (stop_at == nwords) begin
            @(posedge clk); #1;
            n_checks++;
            if ({DoutValid, TaskDone, Full, Empty} !== 4'b0101) begin
                n_fail++;
                $display("FAIL %s done_pulse: {DoutValid,TaskDone,Full,Empty}=%b required 0101",
                         name, {DoutValid, TaskDone, Full, Empty});
            end
            @(posedge clk); #1;
            n_checks++;
            if (TaskDone !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done_one_cycle: TaskDone=%b required 0", name, TaskDone);
            end
`ifdef TBB_STALL_CNT_EN
            n_checks++;
            if (StallCnt !== 32'(stall_len)) begin
                n_fail++;
                $display("FAIL %s stall_cnt: got %0d required %0d", name, StallCnt, stall_len);
            end
`endif
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({Full, Empty, BatchValid, DoutValid, DoutLast, TaskDone} !== 6'b010000) begin
            n_fail++;
            $display("FAIL %s flags: {Full,Empty,BatchValid,DoutValid,DoutLast,TaskDone}=%b required 010000",
                     name, {Full, Empty, BatchValid, DoutValid, DoutLast, TaskDone});
        end
        n_checks++;
        if ({Dout, DoutIdx} !== 44'h0) begin
            n_fail++;
            $display("FAIL %s data: Dout=%h DoutIdx=%h required 0/0", name, Dout, DoutIdx);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_three_lines();
        salt = 8'h00;
        write_line(2, {16{32'h1234_5678}}, 1'b0);
        write_line(0, make_line(0), 1'b0);
        write_line(1, make_line(1), 1'b0);
        write_line(2, make_line(2), 1'b1);
        drain_batch("three_lines", 48, -1, 0, 48);
    endtask

    task automatic test_single_line();
        load_batch(1);
        drain_batch("single_line", 16, -1, 0, 16);
    endtask

    task automatic test_stall_boundary();
        load_batch(2);
        drain_batch("stall_boundary", 32, 16, 2, 32);
    endtask

    task automatic test_ignored_inputs();
        logic seen_valid;
        load_batch(1);
        write_line(0, {16{32'hDEAD_BEEF}}, 1'b0);
        drain_batch("write_in_ready", 16, -1, 0, 16);
        seen_valid = 1'b0;
        TaskStart = 1'b1;
        @(posedge clk); #1;
        TaskStart = 1'b0;
        n_checks++;
        if ({BatchValid, Full} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_in_fill state: {BatchValid,Full}=%b required 00", {BatchValid, Full});
        end
        repeat (4) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | DoutValid;
        end
        n_checks++;
        if (seen_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_fill no_output: DoutValid seen=%b required 0", seen_valid);
        end
    endtask

    task automatic test_full_256();
        load_batch(256);
        drain_batch("full_256", 4096, -1, 0, 4096);
    endtask

    task automatic test_reset_mid_drain();
        logic seen_done;
        load_batch(2);
        drain_batch("pre_reset", 32, -1, 0, 20);
        @(posedge clk); #1;
        n_checks++;
        if ({DoutValid, DoutIdx} !== {1'b1, 12'd20}) begin
            n_fail++;
            $display("FAIL mid_drain_position: DoutValid=%b DoutIdx=%0d required 1/20",
                     DoutValid, DoutIdx);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_drain");
        seen_done = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            seen_done = seen_done | TaskDone;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            seen_done = seen_done | TaskDone;
        end
        n_checks++;
        if (seen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_task_done: TaskDone seen=%b required 0", seen_done);
        end
        salt = 8'h5A;
        load_batch(1);
        drain_batch("post_reset", 16, -1, 0, 16);
    endtask

    initial begin
        test_reset();
        test_three_lines();
        test_single_line();
        test_stall_boundary();
        test_ignored_inputs();
        test_full_256();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
